fft_frame_source: RTL
=====================

Name: fft_frame_source

Overview:
- AXI-stream master that feeds the FFT core.
- Collects real audio samples from the synth sample strobe into FFT_SIZE-sample frames, using a ping-pong buffer.
- Streams each complete frame as complex beats: {im = 0, re = sample}, with tlast on the final beat.
- Upstream end of the FFT -> magnitude chain. Honors tready backpressure and flags frames dropped when the consumer falls behind.

Parameters:
- DATA_WIDTH, 16, width of one real sample and of each complex component.
- FFT_SIZE, 1024, samples per frame; power of two, minimum 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sample_in  input  DATA_WIDTH  signed audio sample.
- sample_valid  input  1  one-cycle strobe; sample_in is captured when high.
- m_axis_tdata  output  2*DATA_WIDTH  bits [DATA_WIDTH-1:0] = re (sample); bits [2*DATA_WIDTH-1:DATA_WIDTH] = im, always 0.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tlast  output  1  high on beat FFT_SIZE-1 of each frame.
- m_axis_tready  input  1  downstream accepts the beat.
- frame_overflow  output  1  one-cycle pulse when a completed frame is discarded.
- overflow_count  output  16  saturating count of discarded frames.

Behaviour:
- Reset (asynchronous assertion):
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, frame_overflow = 0, overflow_count = 0.
  - Write bank = 0, write index = 0, both banks marked free, read FSM in IDLE.
  - Reset mid-frame discards all partial and pending frames. No beat is emitted until a new full frame is collected.
- Storage and write side:
  - Two banks of FFT_SIZE x DATA_WIDTH.
  - Each sample_valid writes sample_in to wr_bank[wr_idx] and increments wr_idx.
  - On the write of index FFT_SIZE-1:
    - If the other bank is free: mark the current bank full, toggle wr_bank, set wr_idx = 0.
    - Otherwise (other bank full or streaming): overflow. The just-completed frame is discarded, wr_bank is unchanged, wr_idx = 0, frame_overflow pulses for 1 cycle the next cycle, and overflow_count increments, saturating at 0xFFFF.
  - Sample collection never stalls. sample_valid has no ready signal.
- Read FSM:
  - IDLE: if any bank is full, select it, rd_idx = 0, go to STREAM. If both banks are full, take the older frame (the bank not equal to wr_bank's previous value, i.e. filled first).
  - STREAM: present beat rd_idx. A handshake occurs when tvalid && tready; rd_idx then increments.
  - On the handshake with tlast: mark the bank free and return to IDLE. If the other bank is already full, go directly to STREAM on it with no idle cycle.
- AXI rules:
  - Once tvalid is high, tvalid, tdata and tlast stay stable until the handshake.
  - tvalid never depends combinationally on tready.
  - With tready held high, a frame occupies exactly FFT_SIZE consecutive tvalid cycles; no bubbles within a frame.
- Latency: first tvalid of a frame rises at most 2 cycles after the clock edge that writes its final sample (when the read side is idle).
- Simultaneous events:
  - Final-tlast handshake and the other bank's completion on the same cycle: the releasing bank counts as free, so there is no overflow and the new frame is accepted.
  - sample_valid during an active stream writes only the write bank and never corrupts the bank being read.
- Arithmetic: samples pass through bit-exact; im is zero-filled. No scaling or windowing.

Test Plan:
- FFT_SIZE=8, tready=1, feed samples 1..8 with strobes every 4 cycles -> 8 beats with re=1..8 and im=0; tlast only on re=8; first tvalid within 2 cycles of sample 8.
- Continuous streaming, 24 samples (3 frames), tready=1 -> 3 frames in order, each 8 contiguous valid cycles; overflow_count=0.
- Backpressure: tready toggled 1,0,0,1 repeating -> tdata and tlast held stable while stalled; all 8 values delivered in order; no beat lost or duplicated.
- Overflow: tready=0 while 24 samples arrive -> frame 1 and frame 2 held; frame 3 dropped with a frame_overflow pulse and overflow_count=1; releasing tready yields frames 1 then 2 only.
- Release coincidence: final tlast handshake of frame 1 lands on the same cycle as the write of sample 8 of frame 3 -> no overflow; frame 3 is streamed after frame 2.
- Reset mid-stream after beat 3 of a frame -> tvalid drops asynchronously and all outputs return to reset values; next output frame contains only samples fed after reset deasserts.

Source files
------------

// File: rtl/fft_frame_source.sv
// Ping-pong frame collector that streams FFT_SIZE-sample frames as complex
// AXI-stream beats {im = 0, re = sample}, dropping frames when the consumer lags.
module fft_frame_source #(
  parameter int DATA_WIDTH = 16,
  parameter int FFT_SIZE   = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   sample_in,
  input  logic                    sample_valid,
  output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    frame_overflow,
  output logic [15:0]             overflow_count
);

  localparam int IW = $clog2(FFT_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(FFT_SIZE - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] mem [0:2*FFT_SIZE-1];
  logic                  wr_bank, rd_bank, load_bank, load;
  logic [IW-1:0]         wr_idx, rd_idx;
  logic [1:0]            full;
  logic                  frame_bad, wr_ok, wr_done, hs, last_hs;

  assign m_axis_tvalid = (state == STREAM);
  assign m_axis_tlast  = m_axis_tvalid && (rd_idx == LAST_IDX);
  assign m_axis_tdata  = m_axis_tvalid ? {{DATA_WIDTH{1'b0}}, mem[{rd_bank, rd_idx}]} : '0;
  assign hs            = m_axis_tvalid && m_axis_tready;
  assign last_hs       = hs && (rd_idx == LAST_IDX);
  assign wr_done       = sample_valid && (wr_idx == LAST_IDX);

  // A write may land in the bank being streamed only on slots already consumed
  // (or consumed this cycle); a frame with any refused write is discarded whole.
  always_comb begin
    wr_ok = 1'b0;
    if (m_axis_tvalid && (rd_bank == wr_bank))
      wr_ok = (wr_idx < rd_idx) || ((wr_idx == rd_idx) && hs);
    else
      wr_ok = !full[wr_bank];
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_bank  = rd_bank;
    unique case (state)
      IDLE: begin
        if (|full) begin
          load       = 1'b1;
          // with both banks full the older frame sits in the bank wr_bank points at
          load_bank  = (&full) ? wr_bank : full[1];
          next_state = STREAM;
        end
      end
      STREAM: begin
        if (last_hs) begin
          if (full[~rd_bank]) begin
            load      = 1'b1;
            load_bank = ~rd_bank;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank        <= 1'b0;
      rd_idx         <= '0;
      wr_bank        <= 1'b0;
      wr_idx         <= '0;
      full           <= '0;
      frame_bad      <= 1'b0;
      frame_overflow <= 1'b0;
      overflow_count <= '0;
    end else begin
      frame_overflow <= 1'b0;
      if (load) begin
        rd_bank         <= load_bank;
        rd_idx          <= '0;
        full[load_bank] <= 1'b0;
      end else if (hs) begin
        rd_idx <= rd_idx + 1'b1;
      end
      if (sample_valid) begin
        if (wr_done) begin
          wr_idx    <= '0;
          frame_bad <= 1'b0;
          if (!frame_bad && wr_ok) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
          end else begin
            frame_overflow <= 1'b1;
            if (overflow_count != '1) overflow_count <= overflow_count + 16'd1;
          end
        end else begin
          wr_idx <= wr_idx + 1'b1;
          if (!wr_ok) frame_bad <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sample_valid && wr_ok) mem[{wr_bank, wr_idx}] <= sample_in;
  end

endmodule
